div_sign_sequencer: RTL

// - Signed/unsigned RISC-V M-extension divide/remainder front-end (DIV, DIVU, REM, REMU) for the RV64 execute stage.
// - Accepts ops over a valid/ready handshake and converts signed operands to magnitudes.
// - Sequences the unsigned no_rest_divisor (start/done), then sign-corrects and returns a 64-bit result.
// - Handles divide-by-zero and signed overflow without starting the divider.

---
 rtl/div_pkg.sv | 15 +
 rtl/no_rest_divisor.sv | 59 +++++
 rtl/div_sign_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divide/remainder sequencer.
// Macro: DIV_WORD_OPS_EN (enables 32-bit W-variant support in the top).
package div_pkg;
    localparam logic [63:0] DIV_MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] DIV_MIN32 = 32'h8000_0000;
    typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
    typedef enum logic [2:0] {IDLE, RUN, FIX, SPEC, RESP} div_state_e;
    function automatic logic [63:0] div_neg(input logic sel, input logic [63:0] x);
        return sel ? -x : x;
    endfunction
    // Most negative value at the active width, sign-extended to 64 bits.
    function automatic logic [63:0] div_min(input logic word);
        return word ? {32'hFFFF_FFFF, DIV_MIN32} : DIV_MIN64;
    endfunction
endpackage

// File: rtl/no_rest_divisor.sv
// no_rest_divisor: unsigned non-restoring divider, one quotient bit per cycle.
// Ports: clk, rst_n (async, active low), start (level; rising start loads operands),
//        dividend/divisor (Size), done (held until start drops), quotient/remainder (Size).
module no_rest_divisor #(
    parameter int Size = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [Size-1:0] dividend,
    input  logic [Size-1:0] divisor,
    output logic            done,
    output logic [Size-1:0] quotient,
    output logic [Size-1:0] remainder
);
    localparam int CW = $clog2(Size + 1);
    logic [CW-1:0]   r_cnt;
    logic            r_busy, r_done;
    logic [Size+1:0] r_p;
    logic [Size-1:0] r_a, r_d;
    logic [Size+1:0] w_sh, w_d, w_nx;
    assign w_sh = {r_p[Size:0], r_a[Size-1]};
    assign w_d  = {2'b00, r_d};
    // Partial remainder sign picks add or subtract; no restore step needed.
    assign w_nx = r_p[Size+1] ? w_sh + w_d : w_sh - w_d;
    assign done      = r_done;
    assign quotient  = r_a;
    assign remainder = r_p[Size-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_p    <= '0;
            r_a    <= '0;
            r_d    <= '0;
        end else if (!start) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (!r_busy && !r_done) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_p    <= '0;
            r_a    <= dividend;
            r_d    <= divisor;
        end else if (r_busy) begin
            if (r_cnt == CW'(Size)) begin
                // Final remainder correction when the last partial remainder is negative.
                r_busy <= 1'b0;
                r_done <= 1'b1;
                if (r_p[Size+1]) r_p <= r_p + w_d;
            end else begin
                r_p   <= w_nx;
                r_a   <= {r_a[Size-2:0], ~w_nx[Size+1]};
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/div_sign_sequencer.sv
// div_sign_sequencer: RV64 M-extension DIV/DIVU/REM/REMU front-end around no_rest_divisor.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, op, [word], rs1, rs2 request side;
//        out_valid/out_ready, result response side; busy when not IDLE.
// Macro: DIV_WORD_OPS_EN adds the word port and 32-bit W-variant ops.
module div_sign_sequencer
    import div_pkg::*;
#(
    parameter int Size = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
`ifdef DIV_WORD_OPS_EN
    input  logic            word,
`endif
    input  logic [Size-1:0] rs1,
    input  logic [Size-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Size-1:0] result,
    output logic            busy
);
    div_state_e      r_state;
    div_op_e         r_op;
    logic            r_word, r_neg_q, r_neg_r, r_dz;
    logic [Size-1:0] r_a, r_b, r_rs1, r_result;
    logic            w_word, w_signed, w_dz, w_ovf, w_start, w_done;
    logic [Size-1:0] w_rs1, w_rs2, w_q, w_r, w_raw, w_fmt;
    assign w_signed = ~op[0];
`ifdef DIV_WORD_OPS_EN
    assign w_word = word;
    assign w_rs1  = w_word ? {{32{w_signed & rs1[31]}}, rs1[31:0]} : rs1;
    assign w_rs2  = w_word ? {{32{w_signed & rs2[31]}}, rs2[31:0]} : rs2;
`else
    assign w_word = 1'b0;
    assign w_rs1  = rs1;
    assign w_rs2  = rs2;
`endif
    assign w_dz  = w_rs2 == '0;
    assign w_ovf = w_signed && w_rs1 == div_min(w_word) && w_rs2 == '1;
    assign w_start   = r_state == RUN;
    assign in_ready  = r_state == IDLE;
    assign busy      = r_state != IDLE;
    assign out_valid = r_state == RESP;
    assign result    = r_result;
    always_comb begin
        w_raw = r_state == SPEC ? (r_dz ? (r_op[1] ? r_rs1 : '1) : (r_op[1] ? '0 : div_min(r_word)))
                                : (r_op[1] ? div_neg(r_neg_r, w_r) : div_neg(r_neg_q, w_q));
        w_fmt = r_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= DIV;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_rs1    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op    <= div_op_e'(op);
                    r_word  <= w_word;
                    r_dz    <= w_dz;
                    r_rs1   <= w_rs1;
                    r_neg_q <= w_signed & (w_rs1[Size-1] ^ w_rs2[Size-1]);
                    r_neg_r <= w_signed & w_rs1[Size-1];
                    r_a     <= div_neg(w_signed & w_rs1[Size-1], w_rs1);
                    r_b     <= div_neg(w_signed & w_rs2[Size-1], w_rs2);
                    r_state <= (w_dz || w_ovf) ? SPEC : RUN;
                end
                RUN:  if (w_done) r_state <= FIX;
                FIX, SPEC: begin
                    r_result <= w_fmt;
                    r_state  <= RESP;
                end
                RESP: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    no_rest_divisor #(.Size(Size)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .dividend (r_a),
        .divisor  (r_b),
        .done     (w_done),
        .quotient (w_q),
        .remainder(w_r)
    );
endmodule
